// File: rtl/huffman_bit_packer.sv
// Packs 1..8-bit codes MSB-first into 32-bit words and flushes a zero-padded last word on finalize.
// Optional build macro HUFFMAN_BIT_COUNT_EN adds the bit_total port and its running code-bit counter.
module huffman_bit_packer #(
  parameter int CODE_W = 8,
  parameter int LEN_W  = 4,
  parameter int WORD_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [CODE_W-1:0] code_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              code_valid,
  input  logic              finalize,
  output logic              code_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic [5:0]        word_bits
`ifdef HUFFMAN_BIT_COUNT_EN
  ,
  output logic [31:0]       bit_total
`endif
);

  localparam int WIN_W  = WORD_W + CODE_W;
  localparam int FILL_W = 6;

  // FLUSH is split: PAD still owes the padded word, DRAIN waits for the last word to be taken.
  typedef enum logic [1:0] {
    ACCUM       = 2'd0,
    FLUSH_PAD   = 2'd1,
    FLUSH_DRAIN = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   acc_reg, acc_next;
  logic [FILL_W-1:0]   fill_reg, fill_next;

  logic [WORD_W-1:0]   word_out_reg;
  logic                word_valid_reg;
  logic                word_last_reg;
  logic [FILL_W-1:0]   word_bits_reg;

  logic                out_free;
  logic                ready_c;
  logic                xfer;
  logic                fin;
  logic [LEN_W-1:0]    len_clip;
  logic [LEN_W-1:0]    eff_len;
  logic [CODE_W-1:0]   code_mask;
  logic [FILL_W-1:0]   total;
  logic [FILL_W-1:0]   shift;
  logic [WIN_W-1:0]    window;
  logic [WORD_W-1:0]   window_hi;
  logic [CODE_W-1:0]   window_lo;
  logic                full;
  logic [WORD_W-1:0]   acc_after;
  logic [FILL_W-1:0]   fill_after;

  logic                load;
  logic [WORD_W-1:0]   ld_word;
  logic                ld_last;
  logic [FILL_W-1:0]   ld_bits;

  assign out_free = !word_valid_reg || word_ready;
  assign ready_c  = (state_reg == ACCUM) && out_free;
  assign xfer     = code_valid && ready_c;
  assign fin      = finalize && ready_c;

  assign len_clip = (len_in > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : len_in;
  assign eff_len  = xfer ? len_clip : '0;

  for (genvar gi = 0; gi < CODE_W; gi++) begin : g_mask
    assign code_mask[gi] = code_in[gi] && (int'(eff_len) > gi);
  end

  // Code MSB lands just below the current fill inside a word-plus-one-code window.
  assign total     = fill_reg + FILL_W'(eff_len);
  assign shift     = FILL_W'(WIN_W) - total;
  assign window    = {acc_reg, {CODE_W{1'b0}}} | (WIN_W'(code_mask) << shift);
  assign window_hi = window[WIN_W-1:CODE_W];
  assign window_lo = window[CODE_W-1:0];
  assign full      = (total >= FILL_W'(WORD_W));
  assign acc_after  = full ? {window_lo, {(WORD_W-CODE_W){1'b0}}} : window_hi;
  assign fill_after = full ? (total - FILL_W'(WORD_W)) : total;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM: begin
        if (fin) begin
          state_next = (full && (fill_after != '0)) ? FLUSH_PAD : FLUSH_DRAIN;
        end
      end
      FLUSH_PAD: begin
        if (out_free) begin
          state_next = FLUSH_DRAIN;
        end
      end
      FLUSH_DRAIN: begin
        if (word_valid_reg && word_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    ld_word   = window_hi;
    ld_last   = 1'b0;
    ld_bits   = FILL_W'(WORD_W);
    acc_next  = acc_reg;
    fill_next = fill_reg;
    case (state_reg)
      ACCUM: begin
        if (ready_c) begin
          acc_next  = acc_after;
          fill_next = fill_after;
          if (full) begin
            load    = 1'b1;
            ld_last = fin && (fill_after == '0);
          end else if (fin) begin
            load      = 1'b1;
            ld_last   = 1'b1;
            ld_bits   = total;
            acc_next  = '0;
            fill_next = '0;
          end
        end
      end
      FLUSH_PAD: begin
        if (out_free) begin
          load      = 1'b1;
          ld_word   = acc_reg;
          ld_last   = 1'b1;
          ld_bits   = fill_reg;
          acc_next  = '0;
          fill_next = '0;
        end
      end
      FLUSH_DRAIN: begin
        acc_next  = '0;
        fill_next = '0;
      end
      default: begin
        acc_next  = '0;
        fill_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_reg  <= '0;
      fill_reg <= '0;
    end else begin
      acc_reg  <= acc_next;
      fill_reg <= fill_next;
    end
  end

  // Single-entry output register; reload on the same edge the old word is consumed is allowed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      word_out_reg   <= '0;
      word_valid_reg <= 1'b0;
      word_last_reg  <= 1'b0;
      word_bits_reg  <= '0;
    end else if (load) begin
      word_out_reg   <= ld_word;
      word_valid_reg <= 1'b1;
      word_last_reg  <= ld_last;
      word_bits_reg  <= ld_bits;
    end else if (word_ready) begin
      word_valid_reg <= 1'b0;
    end
  end

`ifdef HUFFMAN_BIT_COUNT_EN
  logic        stream_done;
  logic [31:0] bit_total_reg;

  assign stream_done = (state_reg == FLUSH_DRAIN) && word_valid_reg && word_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bit_total_reg <= '0;
    end else if (stream_done) begin
      bit_total_reg <= '0;
    end else if (xfer) begin
      bit_total_reg <= bit_total_reg + 32'(len_clip);
    end
  end

  assign bit_total = bit_total_reg;
`endif

  assign code_ready = ready_c;
  assign word_out   = word_out_reg;
  assign word_valid = word_valid_reg;
  assign word_last  = word_last_reg;
  assign word_bits  = word_bits_reg;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Table-driven cycle checks for huffman_bit_packer plus hand sequences for async reset mid-stream.
// With HUFFMAN_BIT_COUNT_EN defined the bit_total counter is also checked.
module tb_huffman_bit_packer;

  logic        clock;
  logic        resetn;
  logic [7:0]  code_in;
  logic [3:0]  len_in;
  logic        code_valid;
  logic        finalize;
  logic        code_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic [5:0]  word_bits;
`ifdef HUFFMAN_BIT_COUNT_EN
  logic [31:0] bit_total;
`endif

  huffman_bit_packer dut (
    .clock      (clock),
    .resetn     (resetn),
    .code_in    (code_in),
    .len_in     (len_in),
    .code_valid (code_valid),
    .finalize   (finalize),
    .code_ready (code_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .word_bits  (word_bits)
`ifdef HUFFMAN_BIT_COUNT_EN
    ,
    .bit_total  (bit_total)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  code;
    logic [3:0]  len;
    logic        cv;
    logic        fin;
    logic        wr;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_word;
    logic        e_last;
    logic [5:0]  e_bits;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic void add(input logic [7:0] code, input logic [3:0] len, input logic cv,
                              input logic fin, input logic wr, input logic e_ready,
                              input logic e_valid, input logic [31:0] e_word,
                              input logic e_last, input logic [5:0] e_bits);
    vecs[nvec].code    = code;
    vecs[nvec].len     = len;
    vecs[nvec].cv      = cv;
    vecs[nvec].fin     = fin;
    vecs[nvec].wr      = wr;
    vecs[nvec].e_ready = e_ready;
    vecs[nvec].e_valid = e_valid;
    vecs[nvec].e_word  = e_word;
    vecs[nvec].e_last  = e_last;
    vecs[nvec].e_bits  = e_bits;
    nvec++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] code, input logic [3:0] len, input logic cv,
                     input logic fin, input logic wr);
    @(negedge clock);
    code_in    = code;
    len_in     = len;
    code_valid = cv;
    finalize   = fin;
    word_ready = wr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // test 1: four bytes
    add(8'h01, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h02, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h03, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h04, 4'd8, 1, 0, 1, 1, 1, 32'h01020304, 0, 6'd32);
    // test 2: three nibbles (upper code bits ignored) then finalize
    add(8'hFA, 4'd4, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h0A, 4'd4, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h0A, 4'd4, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h00, 4'd0, 0, 1, 1, 1, 1, 32'hAAA00000, 1, 6'd12);
    add(8'h00, 4'd0, 0, 0, 1, 0, 0, 32'h0, 0, 6'd0);
    // test 3: straddling code across a word boundary
    for (int i = 0; i < 15; i++) add(8'h01, 4'd2, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h0F, 4'd4, 1, 0, 1, 1, 1, 32'h55555557, 0, 6'd32);
    add(8'h00, 4'd0, 0, 1, 1, 1, 1, 32'hC0000000, 1, 6'd2);
    add(8'h00, 4'd0, 0, 0, 1, 0, 0, 32'h0, 0, 6'd0);
    // test 4: backpressure holds the output word and stalls codes
    add(8'h11, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h22, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h33, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h44, 4'd8, 1, 0, 0, 1, 1, 32'h11223344, 0, 6'd32);
    add(8'h55, 4'd8, 1, 0, 0, 0, 1, 32'h11223344, 0, 6'd32);
    add(8'h55, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h66, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h77, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h88, 4'd8, 1, 0, 0, 1, 1, 32'h55667788, 0, 6'd32);
    add(8'h99, 4'd8, 1, 0, 0, 0, 1, 32'h55667788, 0, 6'd32);
    add(8'h00, 4'd0, 0, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    // test 5: empty finalize, then finalize with a code completing exactly 32 bits
    add(8'h00, 4'd0, 0, 1, 1, 1, 1, 32'h00000000, 1, 6'd0);
    add(8'h00, 4'd0, 0, 0, 1, 0, 0, 32'h0, 0, 6'd0);
    add(8'hAB, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'hCD, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'hEF, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h12, 4'd8, 1, 1, 1, 1, 1, 32'hABCDEF12, 1, 6'd32);
    add(8'h00, 4'd0, 0, 0, 1, 0, 0, 32'h0, 0, 6'd0);
    add(8'h00, 4'd0, 0, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    // length clip, zero length, and finalize with a straddling code: full word then padded word
    add(8'hFF, 4'd15, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'hFF, 4'd0, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h00, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'hFF, 4'd8, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h1F, 4'd5, 1, 0, 1, 1, 0, 32'h0, 0, 6'd0);
    add(8'h3D, 4'd6, 1, 1, 1, 1, 1, 32'hFF00FFFF, 0, 6'd32);
    add(8'h00, 4'd0, 0, 0, 1, 0, 1, 32'hA0000000, 1, 6'd3);
    add(8'h00, 4'd0, 0, 0, 1, 0, 0, 32'h0, 0, 6'd0);
    add(8'h00, 4'd0, 0, 0, 1, 1, 0, 32'h0, 0, 6'd0);

    resetn     = 1'b0;
    code_in    = '0;
    len_in     = '0;
    code_valid = 1'b0;
    finalize   = 1'b0;
    word_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset word_valid", 32'(word_valid), 32'd0);
    chk("reset word_out", word_out, 32'd0);
    chk("reset word_last", 32'(word_last), 32'd0);
    chk("reset word_bits", 32'(word_bits), 32'd0);
    chk("reset code_ready", 32'(code_ready), 32'd1);
`ifdef HUFFMAN_BIT_COUNT_EN
    chk("reset bit_total", bit_total, 32'd0);
`endif
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      @(negedge clock);
      code_in    = vecs[i].code;
      len_in     = vecs[i].len;
      code_valid = vecs[i].cv;
      finalize   = vecs[i].fin;
      word_ready = vecs[i].wr;
      #1;
      chk($sformatf("vec%0d code_ready", i), 32'(code_ready), 32'(vecs[i].e_ready));
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d word_valid", i), 32'(word_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d word_out", i), word_out, vecs[i].e_word);
        chk($sformatf("vec%0d word_last", i), 32'(word_last), 32'(vecs[i].e_last));
        chk($sformatf("vec%0d word_bits", i), 32'(word_bits), 32'(vecs[i].e_bits));
      end
      $display("[TB] vec %0d code=%h len=%0d cv=%b fin=%b wr=%b -> valid=%b word=%h last=%b bits=%0d",
               i, vecs[i].code, vecs[i].len, vecs[i].cv, vecs[i].fin, vecs[i].wr,
               word_valid, word_out, word_last, word_bits);
    end

    // async reset after 20 bits: outputs clear without a clock edge, stream restarts at bit 31
    cyc(8'hFF, 4'd8, 1, 0, 1);
    cyc(8'hFF, 4'd8, 1, 0, 1);
    cyc(8'h0F, 4'd4, 1, 0, 1);
    code_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("midreset word_out", word_out, 32'd0);
    chk("midreset word_valid", 32'(word_valid), 32'd0);
    chk("midreset word_last", 32'(word_last), 32'd0);
    chk("midreset word_bits", 32'(word_bits), 32'd0);
`ifdef HUFFMAN_BIT_COUNT_EN
    chk("midreset bit_total", bit_total, 32'd0);
`endif
    $display("[TB] async reset mid-stream -> valid=%b word=%h last=%b bits=%0d",
             word_valid, word_out, word_last, word_bits);
    @(negedge clock);
    resetn = 1'b1;

    cyc(8'h0A, 4'd4, 1, 0, 1);
    cyc(8'h0A, 4'd4, 1, 0, 1);
    cyc(8'h0A, 4'd4, 1, 0, 1);
`ifdef HUFFMAN_BIT_COUNT_EN
    chk("post-reset bit_total", bit_total, 32'd12);
`endif
    cyc(8'h00, 4'd0, 0, 1, 1);
    chk("post-reset word_valid", 32'(word_valid), 32'd1);
    chk("post-reset word_out", word_out, 32'hAAA00000);
    chk("post-reset word_last", 32'(word_last), 32'd1);
    chk("post-reset word_bits", 32'(word_bits), 32'd12);
    $display("[TB] post-reset stream -> valid=%b word=%h last=%b bits=%0d",
             word_valid, word_out, word_last, word_bits);
    cyc(8'h00, 4'd0, 0, 0, 1);
    chk("post-drain word_valid", 32'(word_valid), 32'd0);
`ifdef HUFFMAN_BIT_COUNT_EN
    chk("post-drain bit_total", bit_total, 32'd0);
`endif
    @(negedge clock);
    #1;
    chk("post-drain code_ready", 32'(code_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
